// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit stage between EX and the data-memory bus.
// Accepts one aligned load or store at a time, issues a single bus request
// and writes back sign- or zero-extended load data one cycle after rvalid.
// Misaligned accesses raise a one-cycle exception pulse and never reach the bus.
module lsu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        lsu_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        is_load_s;
    logic        is_store_s;
    logic        legal_s;
    logic        aligned_s;
    logic        start_s;
    logic        misalign_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    logic [1:0]  off_r;
    logic [2:0]  funct3_r;
    logic [4:0]  rd_r;

    logic [31:0] byte_sh_s;
    logic [31:0] half_sh_s;
    logic [31:0] ext_s;

    // Decode the EX-stage op: type priority, legality, alignment, lanes.
    always_comb begin
        is_load_s  = ex_is_load;
        is_store_s = ex_is_store & ~ex_is_load;
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: legal_s = is_load_s | is_store_s;
            3'b100, 3'b101:         legal_s = is_load_s;
            default:                legal_s = 1'b0;
        endcase
        case (ex_funct3[1:0])
            2'b00: begin
                aligned_s = 1'b1;
                be_s      = 4'b0001 << ex_addr[1:0];
                wdata_s   = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                aligned_s = ~ex_addr[0];
                be_s      = 4'b0011 << ex_addr[1:0];
                wdata_s   = {2{ex_wdata[15:0]}};
            end
            default: begin
                aligned_s = (ex_addr[1:0] == 2'b00);
                be_s      = 4'b1111;
                wdata_s   = ex_wdata;
            end
        endcase
        if ((state_r == ST_IDLE) && ex_valid && legal_s) begin
            start_s    = aligned_s;
            misalign_s = ~aligned_s;
        end else begin
            start_s    = 1'b0;
            misalign_s = 1'b0;
        end
    end

    // Extract and extend the addressed lane of the returned read word.
    always_comb begin
        byte_sh_s = dmem_rdata >> {off_r, 3'b000};
        half_sh_s = dmem_rdata >> {off_r[1], 4'b0000};
        case (funct3_r)
            3'b000:  ext_s = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
            3'b001:  ext_s = {{16{half_sh_s[15]}}, half_sh_s[15:0]};
            3'b100:  ext_s = {24'd0, byte_sh_s[7:0]};
            3'b101:  ext_s = {16'd0, half_sh_s[15:0]};
            default: ext_s = dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: one request, then wait for read data on loads.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    state_nxt_s = dmem_we ? ST_IDLE : ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stall output: hold upstream until this op no longer needs the EX fields.
    always_comb begin
        case (state_r)
            ST_IDLE: lsu_stall = start_s;
            ST_REQ:  lsu_stall = ~(dmem_gnt & dmem_we);
            ST_WAIT: lsu_stall = ~dmem_rvalid;
            default: lsu_stall = 1'b0;
        endcase
    end

    // Latch the request fields on start; they stay stable through the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            off_r      <= 2'd0;
            funct3_r   <= 3'd0;
            rd_r       <= 5'd0;
        end else begin
            if (start_s) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store_s;
                dmem_addr  <= {ex_addr[31:2], 2'b00};
                dmem_be    <= be_s;
                dmem_wdata <= wdata_s;
                off_r      <= ex_addr[1:0];
                funct3_r   <= ex_funct3;
                rd_r       <= ex_rd;
            end else if ((state_r == ST_REQ) && dmem_gnt) begin
                dmem_req <= 1'b0;
            end
        end
    end

    // Register the load writeback; data holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            if ((state_r == ST_WAIT) && dmem_rvalid) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_r;
                wb_data  <= ext_s;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    // One-cycle misaligned-access report with the offending address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_exc  <= 1'b0;
            misalign_addr <= 32'd0;
        end else begin
            misalign_exc <= misalign_s;
            if (misalign_s) begin
                misalign_addr <= ex_addr;
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Testbench for lsu_stage: a driver issues directed and random ops and plays
// the memory side; expected bus requests, writebacks and exceptions are
// queued from a reference model and checked by an independent monitor.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        lsu_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    lsu_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .lsu_stall(lsu_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_t;
    typedef struct { logic [31:0] addr; int cyc; } exc_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    exc_t exc_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] last_wb = 32'd0;
    bus_t        mb;
    wb_t         mw;
    exc_t        me;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare whenever the DUT presents a response.
    always @(negedge clk) begin
        if (dmem_req && dmem_gnt) begin
            if (bus_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_req: addr 0x%08h, none expected", dmem_addr);
            end else begin
                mb = bus_q.pop_front();
                check("bus_addr", dmem_addr, mb.addr);
                check("bus_be", 32'(dmem_be), 32'(mb.be));
                check("bus_we", 32'(dmem_we), 32'(mb.we));
                if (mb.we) check("bus_wdata", dmem_wdata, mb.wdata);
            end
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_wb: data 0x%08h, none expected", wb_data);
            end else begin
                mw = wb_q.pop_front();
                check("wb_rd", 32'(wb_rd), 32'(mw.rd));
                check("wb_data", wb_data, mw.data);
                check("wb_cycle", 32'(cyc), 32'(mw.cyc));
                last_wb = mw.data;
            end
        end else if (rst_n) begin
            check("wb_hold", wb_data, last_wb);
        end
        if (misalign_exc) begin
            if (exc_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_exc: addr 0x%08h, none expected", misalign_addr);
            end else begin
                me = exc_q.pop_front();
                check("exc_addr", misalign_addr, me.addr);
                check("exc_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
    end

    // Reference model of one op; drives EX fields and the memory side.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input int gd, input int rv, input logic [31:0] rdat);
        logic        is_ld, is_st, legal, aligned;
        int          sz;
        logic [3:0]  be;
        logic [31:0] wexp, base;
        longint      v;
        is_ld   = ld;
        is_st   = st && !ld;
        sz      = 1 << f3[1:0];
        legal   = (is_ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                  (is_st && (f3 inside {3'd0, 3'd1, 3'd2}));
        aligned = ((a % sz) == 0);
        base    = a - (a % 4);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
        ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
        if (!legal) begin
            @(negedge clk);
            check("ignored_stall", 32'(lsu_stall), 32'd0);
            @(posedge clk); #1;
            ex_valid = 1'b0;
        end else if (!aligned) begin
            @(negedge clk);
            check("misalign_stall", 32'(lsu_stall), 32'd0);
            exc_q.push_back('{addr: a, cyc: cyc + 1});
            @(posedge clk); #1;
            ex_valid = 1'b0;
        end else begin
            be   = 4'(((1 << sz) - 1) << (a % 4));
            wexp = (sz == 1) ? wd[7:0] * 32'h01010101 :
                   (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
            bus_q.push_back('{addr: base, be: be, we: is_st, wdata: wexp});
            @(negedge clk);
            check("start_stall", 32'(lsu_stall), 32'd1);
            @(posedge clk); #1;
            for (int k = 0; k <= gd; k++) begin
                dmem_gnt    = (k == gd);
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata  = $urandom;
                @(negedge clk);
                check("req_held", 32'(dmem_req), 32'd1);
                check("req_stall", 32'(lsu_stall), (is_st && k == gd) ? 32'd0 : 32'd1);
                check("req_addr", dmem_addr, base);
                check("req_be", 32'(dmem_be), 32'(be));
                @(posedge clk); #1;
            end
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (is_ld) begin
                v = longint'((rdat >> (8 * (a % 4)))) % (64'sd1 << (8 * sz));
                if (!f3[2] && sz < 4 && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
                for (int j = 0; j <= rv; j++) begin
                    dmem_rvalid = (j == rv);
                    dmem_rdata  = (j == rv) ? rdat : $urandom;
                    @(negedge clk);
                    check("wait_req", 32'(dmem_req), 32'd0);
                    check("wait_stall", 32'(lsu_stall), (j == rv) ? 32'd0 : 32'd1);
                    if (j == rv) wb_q.push_back('{rd: rd, data: 32'(v), cyc: cyc + 1});
                    @(posedge clk); #1;
                end
                dmem_rvalid = 1'b0;
            end
            ex_valid = 1'b0;
        end
    endtask

    // Idle cycles with stray rvalid pulses that must be ignored.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            ex_valid    = 1'b0;
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
            @(negedge clk);
            check("idle_stall", 32'(lsu_stall), 32'd0);
            check("idle_req", 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ld, st;
        logic [2:0] f3;
        int         kind, r;
        rst_n = 1'b1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
        ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_exc", 32'(misalign_exc), 32'd0);
        check("rst_exc_addr", misalign_addr, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 1, 0, 32'd0);
        idle(1);
        do_op(1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 5'd2, 0, 0, 32'h80112233);
        do_op(1'b1, 1'b0, 3'b100, 32'h203, 32'd0, 5'd3, 0, 1, 32'h80112233);
        do_op(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 5'd4, 0, 0, 32'd0);
        do_op(1'b1, 1'b0, 3'b010, 32'h6, 32'd0, 5'd5, 0, 0, 32'd0);
        idle(2);
        do_op(1'b1, 1'b0, 3'b001, 32'h302, 32'd0, 5'd6, 3, 2, 32'h9ABC0000);
        do_op(1'b1, 1'b1, 3'b100, 32'h41, 32'd0, 5'd8, 0, 0, 32'h0000C300);
        do_op(1'b0, 1'b1, 3'b100, 32'h50, 32'h1, 5'd9, 0, 0, 32'd0);
        do_op(1'b1, 1'b0, 3'b011, 32'h50, 32'h1, 5'd9, 0, 0, 32'd0);
        idle(2);

        // Reset while waiting for read data; the late rvalid must be dropped.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h40; ex_rd = 5'd7;
        bus_q.push_back('{addr: 32'h40, be: 4'hF, we: 1'b0, wdata: 32'd0});
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("wait_before_rst", 32'(lsu_stall), 32'd1);
        #2;
        ex_valid = 1'b0; last_wb = 32'd0; rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_stall", 32'(lsu_stall), 32'd0);
        check("rst_mid_wb", 32'(wb_valid), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        check("late_rvalid_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        idle(3);

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            ld = (kind == 0) || (kind >= 2 && kind <= 5);
            st = (kind == 0) || (kind >= 6);
            r  = $urandom_range(0, 4);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (ld)                   f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            else                           f3 = 3'($urandom_range(0, 2));
            do_op(ld, st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("wb_q_empty", 32'(wb_q.size()), 32'd0);
        check("exc_q_empty", 32'(exc_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ex_valid  in  1  EX-stage instruction valid.
REQ-005 ex_is_load, ex_is_store  in  1 each  memory op type; load wins if both are high.
REQ-006 ex_funct3  in  3  width/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-007 ex_addr  in  32  effective address (ALU result).
REQ-008 ex_wdata  in  32  store source (rs2).
REQ-009 ex_rd  in  5  load destination register.
REQ-010 lsu_stall  out  1  hold the upstream pipeline; ex_* are stable while it is high.
REQ-011 dmem_req, dmem_we  out  1 each  bus request and write enable.
REQ-012 dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-013 dmem_be  out  4  byte enables.
REQ-014 dmem_wdata  out  32  lane-replicated store data.
REQ-015 dmem_gnt, dmem_rvalid  in  1 each  request accepted; read data valid.
REQ-016 dmem_rdata  in  32  read word.
REQ-017 wb_valid  out  1  load result valid, 1-cycle pulse.
REQ-018 wb_rd  out  5  load destination register.
REQ-019 wb_data  out  32  extended load result.
REQ-020 misalign_exc  out  1  misaligned-access pulse.
REQ-021 misalign_addr  out  32  offending address.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, REQ, WAIT.
REQ-023 start = IDLE & ex_valid & (load|store) & legal funct3 & aligned; aligned means half: addr[0]=0, word: addr[1:0]=00, byte: always.
REQ-024 On start, the block SHALL latch addr, funct3, rd, we, be and wdata, and go to REQ next cycle.
REQ-025 Misaligned op in IDLE: no bus request, no state change; misalign_exc=1 and misalign_addr=ex_addr on the next cycle, for exactly one cycle.
REQ-026 Illegal funct3 (load 011/110/111, store 1xx/011): ignored; no request, no stall, no exception.
REQ-027 REQ: dmem_req=1 and dmem_* driven from latched registers and held stable until dmem_gnt.
REQ-028 REQ & gnt & store: next state IDLE.
REQ-029 REQ & gnt & load: next state WAIT.
REQ-030 WAIT: dmem_req=0; on dmem_rvalid go to IDLE; rvalid SHALL be ignored in any state other than WAIT.
REQ-031 lsu_stall = (IDLE & start) | (REQ & !(gnt & store)) | (WAIT & !rvalid); combinational.
REQ-032 Min latency: store 2 cycles (start, REQ+gnt); load 3 cycles (start, REQ+gnt, WAIT+rvalid).
REQ-033 Store be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-034 Store wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-035 Load be SHALL use the same enables as stores; dmem_we=0.
REQ-036 Load extract: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]).
REQ-037 Load extend: LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
REQ-038 wb_valid, wb_rd and wb_data SHALL be registered and valid the cycle after the rvalid cycle; wb_data holds its value when wb_valid=0.
REQ-039 Stores never assert wb_valid.
REQ-040 Back-to-back ops: a new start SHALL be possible the cycle after a return to IDLE.

Reset
REQ-041 On rst_n low, asynchronously: state=IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, misalign_exc=0, misalign_addr=0.
REQ-042 Reset mid-transaction SHALL abort it, with no wb_valid afterwards, and a late rvalid SHALL be ignored.

Verification
REQ-043 SW addr=0x100, wdata=0xDEADBEEF, gnt one cycle after req -> addr 0x100, be 1111, we=1, stall drops in the gnt cycle, no wb_valid.
REQ-044 LB addr=0x203, rdata=0x80112233 -> be 1000, wb_data=0xFFFFFF80; same with LBU -> 0x00000080.
REQ-045 SH addr=0x12, wdata=0x0000ABCD -> dmem_addr 0x10, be 1100, wdata 0xABCDABCD.
REQ-046 LW addr=0x6 -> no dmem_req, misalign_exc one pulse, misalign_addr=0x6, lsu_stall stays 0.
REQ-047 LH with gnt delayed 3 cycles and rvalid delayed 2 more -> request fields stable throughout, stall high throughout, wb_valid once.
REQ-048 rst_n low while in WAIT, then rvalid -> IDLE, dmem_req=0, wb_valid never asserted.
